modn_counter_ctrl: RTL and testbench
====================================

Name: modn_counter_ctrl

Overview:
- Controller that sequences a programmable mod-N up-counting resource: holds the modulus, starts, pauses, resumes and stops counting, and flags terminal count.
- Sits between a simple host or control strobe interface and the counting datapath.
- Supports one-shot and periodic modes and reports status (busy, done, error) for the timing and sequencing logic above it.

Parameters:
- W, 4, width of modulus and count; must satisfy 2^W >= max N.
- DEFAULT_N, 8, modulus loaded at reset; must be 1..2^W-1.
- PCNT_W, 8, width of the saturating completed-period counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cfg_we  input  1  configuration write strobe.
- cfg_n  input  W  modulus to load on cfg_we.
- cfg_oneshot  input  1  mode to load on cfg_we (1 = one-shot, 0 = periodic).
- start  input  1  start/resume pulse.
- pause  input  1  pause pulse.
- stop  input  1  abort pulse.
- count  output  W  current count value.
- tc  output  1  terminal-count pulse, one cycle.
- busy  output  1  high in RUN or HOLD.
- done  output  1  high in DONE (one-shot complete).
- err  output  1  one-cycle error pulse.
- periods  output  PCNT_W  completed periods since last start from IDLE/DONE, saturating.

Behaviour:
- Reset values: count=0, tc=0, busy=0, done=0, err=0, periods=0, state=IDLE, n_reg=DEFAULT_N, oneshot_reg=0.
- All outputs are registered.
- States: IDLE, RUN, HOLD, DONE.
- Config:
  - cfg_we is accepted only in IDLE or DONE; it loads n_reg and oneshot_reg at the next edge.
  - cfg_we in RUN/HOLD is ignored (registers unchanged) and pulses err next cycle.
- Start from IDLE/DONE:
  - If n_reg==0: stay in the current state, pulse err.
  - Else: go to RUN, count=0, periods=0, done=0.
  - The first increment occurs on the edge after entry to RUN.
  - A cfg_we and a start in the same cycle: the start uses the old n_reg.
- RUN, each cycle:
  - If count==n_reg-1: count becomes 0, tc=1 for exactly that next cycle, periods increments (saturates at all-ones).
  - Otherwise count increments by 1.
- Wrap behaviour by mode:
  - Periodic: stays in RUN indefinitely.
  - One-shot: at the wrap goes to DONE; count=0, tc=1, done=1 in the same cycle.
- n_reg==1: count stays 0 and tc pulses every RUN cycle (one-shot: a single tc, then DONE).
- pause in RUN: go to HOLD; count and periods freeze at their value after the current edge is suppressed (no increment on that edge); tc=0.
- start in HOLD: resume RUN; counting continues from the frozen value on the following edge.
- start in RUN: ignored.
- pause outside RUN: ignored.
- stop in RUN, HOLD or DONE: go to IDLE; count=0, done=0, tc=0. periods holds its value.
- Same-cycle priority: stop > pause > start. Example: pause+start in RUN gives HOLD.
- Reset mid-operation: immediate asynchronous return to the reset values; no tc or err is generated.
- Arithmetic: compare against n_reg-1 in W bits. count never exceeds n_reg-1.

Optional Feature:
- Macro: MODN_CTRL_PRESCALE_EN.
- When defined:
  - Adds parameter PRESCALE (default 4, >=1) and an internal prescale counter.
  - In RUN, count advances only on every PRESCALE-th cycle. tc and wrap logic are evaluated only on those advance cycles.
  - The prescaler clears on entry to RUN from IDLE/DONE, holds in HOLD, and clears on stop/reset.
- When undefined: count advances every RUN cycle and there is no prescaler logic.

Test Plan:
- Reset release, no stimulus -> count=0, busy=0, done=0, periods=0 for 20 cycles; a start then counts 0..7 (DEFAULT_N=8).
- cfg_n=5, periodic, start -> count 0,1,2,3,4,0,...; tc high on each return to 0; periods=3 after 15 RUN cycles.
- cfg_n=3, one-shot, start -> count 0,1,2,0; tc and done assert together; busy=0. A second start restarts with done cleared.
- Periodic N=6: pause at count=3, wait 10 cycles (count holds 3, tc=0), start -> 4,5,0 with tc. Pause+start in the same cycle -> HOLD.
- cfg_we during RUN (cfg_n=2) -> err pulse, period stays 6. cfg_n=0 then start -> err pulse, stays IDLE.
- Stop at count=4 -> count=0, IDLE next cycle. Assert reset (low) mid-RUN -> all outputs immediately take their reset values. With MODN_CTRL_PRESCALE_EN and PRESCALE=4, N=3: tc every 12 cycles.

Source files
------------

// File: rtl/modn_counter_ctrl.sv
// Mod-N up-counter sequencer: IDLE/RUN/HOLD/DONE control, one-shot or periodic wrap, status flags.
// Optional prescaler on count advance enabled by defining MODN_CTRL_PRESCALE_EN.
module modn_counter_ctrl #(
    parameter int unsigned W         = 4,
    parameter int unsigned DEFAULT_N = 8,
    parameter int unsigned PCNT_W    = 8
`ifdef MODN_CTRL_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE  = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [W-1:0]      cfg_n,
    input  logic              cfg_oneshot,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [W-1:0]      count,
    output logic              tc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PCNT_W-1:0] periods
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [W-1:0]      count_q, count_d;
    logic              tc_q, tc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [PCNT_W-1:0] periods_q, periods_d;
    logic [W-1:0]      n_q, n_d;
    logic              oneshot_q, oneshot_d;

    logic idle_like;
    logic active;
    logic start_ok;
    logic start_err;
    logic cfg_err;
    logic running;
    logic tick;
    logic wrap;
    logic advance;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign active    = (state_q == S_RUN) || (state_q == S_HOLD);
    // A start that coincides with stop is dropped: stop has the highest priority.
    assign start_ok  = start && !stop && idle_like && (n_q != '0);
    assign start_err = start && !stop && idle_like && (n_q == '0);
    assign cfg_err   = cfg_we && active;
    assign running   = (state_q == S_RUN) && !stop && !pause;
    assign wrap      = (count_q == (n_q - W'(1)));
    assign advance   = running && tick;

`ifdef MODN_CTRL_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] pre_q, pre_d;

    assign tick = (pre_q == PS_W'(PRESCALE - 1));

    always_comb begin
        pre_d = pre_q;
        if (stop && (state_q != S_IDLE)) begin
            pre_d = '0;
        end else if (start_ok) begin
            pre_d = '0;
        end else if (running) begin
            pre_d = tick ? '0 : pre_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop)                             state_d = S_IDLE;
                else if (pause)                       state_d = S_HOLD;
                else if (advance && wrap && oneshot_q) state_d = S_DONE;
            end
            S_HOLD: begin
                if (stop)       state_d = S_IDLE;
                else if (start) state_d = S_RUN;
            end
            S_DONE: begin
                if (stop)          state_d = S_IDLE;
                else if (start_ok) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        done_d    = done_q;
        periods_d = periods_q;
        err_d     = cfg_err || start_err;
        busy_d    = (state_d == S_RUN) || (state_d == S_HOLD);
        n_d       = n_q;
        oneshot_d = oneshot_q;

        if (stop && (state_q != S_IDLE)) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (start_ok) begin
            count_d   = '0;
            periods_d = '0;
            done_d    = 1'b0;
        end else if (advance) begin
            if (wrap) begin
                count_d = '0;
                tc_d    = 1'b1;
                if (periods_q != '1) periods_d = periods_q + PCNT_W'(1);
                if (oneshot_q) done_d = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end

        if (cfg_we && idle_like) begin
            n_d       = cfg_n;
            oneshot_d = cfg_oneshot;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            periods_q <= '0;
            n_q       <= W'(DEFAULT_N);
            oneshot_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            periods_q <= periods_d;
            n_q       <= n_d;
            oneshot_q <= oneshot_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign periods = periods_q;

endmodule

// File: tb/tb_modn_counter_ctrl.sv
// Directed self-checking bench for modn_counter_ctrl in its default build (no prescaler).
module tb_modn_counter_ctrl;

    localparam int unsigned W      = 4;
    localparam int unsigned PCNT_W = 8;

    logic              clk;
    logic              reset;
    logic              cfg_we;
    logic [W-1:0]      cfg_n;
    logic              cfg_oneshot;
    logic              start;
    logic              pause;
    logic              stop;
    logic [W-1:0]      count;
    logic              tc;
    logic              busy;
    logic              done;
    logic              err;
    logic [PCNT_W-1:0] periods;

    int unsigned n_chk;
    int unsigned n_bad;

    modn_counter_ctrl #(
        .W         (W),
        .DEFAULT_N (8),
        .PCNT_W    (PCNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_n       (cfg_n),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .periods     (periods)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge, then pulses drop.
    task automatic step();
        @(posedge clk);
        #1;
        start  = 1'b0;
        pause  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic cfg(input logic [W-1:0] n, input logic os);
        cfg_we      = 1'b1;
        cfg_n       = n;
        cfg_oneshot = os;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b0;
        cfg_we = 1'b0;
        cfg_n = '0;
        cfg_oneshot = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop = 1'b0;

        #3;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tc", tc, 0);
        chk("rst_err", err, 0);
        step();
        step();
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_count", count, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_periods", periods, 0);
        end

        // Default modulus 8
        start = 1'b1; step();
        chk("def_start_count", count, 0);
        chk("def_start_busy", busy, 1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("def_count", count, i);
            chk("def_tc", tc, 0);
        end
        step();
        chk("def_wrap_count", count, 0);
        chk("def_wrap_tc", tc, 1);
        chk("def_wrap_periods", periods, 1);
        stop = 1'b1; step();
        chk("def_stop_busy", busy, 0);
        chk("def_stop_periods", periods, 1);

        // Periodic N=5, with an ignored start mid-run
        cfg(4'd5, 1'b0);
        start = 1'b1; step();
        chk("p5_start_count", count, 0);
        chk("p5_start_periods", periods, 0);
        for (int i = 1; i <= 15; i++) begin
            if (i == 7) start = 1'b1;
            step();
            chk("p5_count", count, i % 5);
            chk("p5_tc", tc, (i % 5 == 0) ? 1 : 0);
        end
        chk("p5_periods", periods, 3);
        stop = 1'b1; step();

        // One-shot N=3
        cfg(4'd3, 1'b1);
        start = 1'b1; step();
        chk("os_start_done", done, 0);
        step(); chk("os_c1", count, 1);
        step(); chk("os_c2", count, 2);
        step();
        chk("os_wrap_count", count, 0);
        chk("os_wrap_tc", tc, 1);
        chk("os_wrap_done", done, 1);
        chk("os_wrap_busy", busy, 0);
        chk("os_wrap_periods", periods, 1);
        step();
        chk("os_after_tc", tc, 0);
        chk("os_after_done", done, 1);
        chk("os_after_count", count, 0);
        start = 1'b1; step();
        chk("os_restart_done", done, 0);
        chk("os_restart_busy", busy, 1);
        chk("os_restart_periods", periods, 0);
        step(); chk("os_restart_c1", count, 1);
        stop = 1'b1; step();
        chk("os_stop_busy", busy, 0);
        chk("os_stop_done", done, 0);

        // Periodic N=6 pause/resume
        cfg(4'd6, 1'b0);
        start = 1'b1; step();
        step(); step(); step();
        chk("pz_pre", count, 3);
        pause = 1'b1; step();
        chk("pz_frozen", count, 3);
        chk("pz_busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pz_hold_count", count, 3);
            chk("pz_hold_tc", tc, 0);
        end
        start = 1'b1; step();
        chk("pz_resume_edge", count, 3);
        step(); chk("pz_c4", count, 4);
        step(); chk("pz_c5", count, 5);
        step();
        chk("pz_wrap", count, 0);
        chk("pz_wrap_tc", tc, 1);
        chk("pz_wrap_periods", periods, 1);
        pause = 1'b1; start = 1'b1; step();
        chk("pz_ps_count", count, 0);
        chk("pz_ps_tc", tc, 0);
        step();
        chk("pz_ps_hold", count, 0);
        chk("pz_ps_busy", busy, 1);
        start = 1'b1; step();
        step(); chk("pz_ps_resume", count, 1);
        stop = 1'b1; step();

        // Config write while running is rejected
        start = 1'b1; step();
        cfg(4'd2, 1'b0);
        chk("cw_count", count, 1);
        chk("cw_err", err, 1);
        step();
        chk("cw_count2", count, 2);
        chk("cw_err_clr", err, 0);
        step(); step(); step();
        chk("cw_count5", count, 5);
        step();
        chk("cw_wrap", count, 0);
        chk("cw_wrap_tc", tc, 1);
        stop = 1'b1; step();

        // N=0 start error
        cfg(4'd0, 1'b0);
        chk("z_cfg_err", err, 0);
        start = 1'b1; step();
        chk("z_err", err, 1);
        chk("z_busy", busy, 0);
        step();
        chk("z_err_clr", err, 0);
        chk("z_still_idle", busy, 0);

        // N=1 periodic: tc every cycle and periods saturates
        cfg(4'd1, 1'b0);
        start = 1'b1; step();
        chk("n1_start_tc", tc, 0);
        step();
        chk("n1_tc", tc, 1);
        chk("n1_count", count, 0);
        chk("n1_periods", periods, 1);
        for (int i = 0; i < 260; i++) step();
        chk("n1_sat", periods, 255);
        chk("n1_sat_tc", tc, 1);
        stop = 1'b1; step();
        chk("n1_stop_periods", periods, 255);
        chk("n1_stop_tc", tc, 0);

        // N=1 one-shot
        cfg(4'd1, 1'b1);
        start = 1'b1; step();
        chk("n1os_periods", periods, 0);
        step();
        chk("n1os_tc", tc, 1);
        chk("n1os_done", done, 1);
        chk("n1os_busy", busy, 0);
        step();
        chk("n1os_single_tc", tc, 0);

        // Stop mid-count
        cfg(4'd6, 1'b0);
        start = 1'b1; step();
        step(); step(); step(); step();
        chk("st_pre", count, 4);
        stop = 1'b1; step();
        chk("st_count", count, 0);
        chk("st_busy", busy, 0);

        // Asynchronous reset mid-run
        start = 1'b1; step();
        step(); step(); step();
        chk("ar_pre", count, 3);
        #2 reset = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_tc", tc, 0);
        chk("ar_err", err, 0);
        chk("ar_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1; step();
        for (int i = 1; i < 8; i++) step();
        chk("ar_default_n7", count, 7);
        step();
        chk("ar_default_wrap", count, 0);
        chk("ar_default_tc", tc, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
